// File: rtl/minx16_pkg.sv
// Shared definitions for the Minx16 execute stage: op codes, write modes,
// flag positions, FSM states and a flag-packing helper.
package minx16_pkg;

   typedef enum logic [3:0] {
      OP_ADD = 4'd0,
      OP_SUB = 4'd1,
      OP_AND = 4'd2,
      OP_OR  = 4'd3,
      OP_XOR = 4'd4,
      OP_MOV = 4'd5,
      OP_SHL = 4'd6,
      OP_SHR = 4'd7,
      OP_SAR = 4'd8,
      OP_MUL = 4'd9,
      OP_CMP = 4'd10
   } op_e;

   localparam logic [2:0] WD_NONE  = 3'b000;
   localparam logic [2:0] WD_LO    = 3'b001;
   localparam logic [2:0] WD_HI    = 3'b010;
   localparam logic [2:0] WD_FULL  = 3'b011;
   localparam logic [2:0] WD_SWAP0 = 3'b100;
   localparam logic [2:0] WD_SWAP1 = 3'b101;
   localparam logic [2:0] WD_SWAP2 = 3'b110;
   localparam logic [2:0] WD_SWAP3 = 3'b111;

   localparam int unsigned FLAG_Z = 3;
   localparam int unsigned FLAG_N = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_MUL   = 2'd1,
      ST_SHIFT = 2'd2
   } state_e;

   function automatic logic [3:0] mk_flags(logic [15:0] res, logic c, logic v);
      logic [3:0] f;
      f         = '0;
      f[FLAG_Z] = (res == 16'h0000);
      f[FLAG_N] = res[15];
      f[FLAG_C] = c;
      f[FLAG_V] = v;
      return f;
   endfunction

endpackage

// File: rtl/minx16_if.sv
// Decoder-to-execute bus: op issue handshake plus register-file write port and flags.
interface minx16_if #(parameter int A = 3);
   logic           in_valid;
   logic           in_ready;
   logic [3:0]     op;
   logic [A-1:0]   dst;
   logic [2:0]     wmode;
   logic [15:0]    a;
   logic [15:0]    b;
   logic [A-1:0]   rd;
   logic [15:0]    dd;
   logic [2:0]     wd;
   logic [3:0]     flags;
   logic           busy;

   modport master (
      output in_valid, op, dst, wmode, a, b,
      input  in_ready, rd, dd, wd, flags, busy
   );

   modport slave (
      input  in_valid, op, dst, wmode, a, b,
      output in_ready, rd, dd, wd, flags, busy
   );
endinterface

// File: rtl/minx16_addsub.sv
// 16-bit adder/subtractor; C is carry for add and borrow (x<y unsigned) for sub.
module minx16_addsub (
   input  logic [15:0] i_x,
   input  logic [15:0] i_y,
   input  logic        i_sub,
   output logic [15:0] o_sum,
   output logic        o_c,
   output logic        o_v
);
   logic [15:0] w_y;
   logic        w_cout;

   always_comb begin
      w_y             = i_sub ? ~i_y : i_y;
      {w_cout, o_sum} = {1'b0, i_x} + {1'b0, w_y} + {16'd0, i_sub};
      o_c             = i_sub ? ~w_cout : w_cout;
      o_v             = (i_x[15] == w_y[15]) && (o_sum[15] != i_x[15]);
   end
endmodule

// File: rtl/minx16_exec.sv
// Minx16 execute stage: single-cycle ALU ops plus iterative MUL and shifts
// that stall issue while in progress.
module minx16_exec
   import minx16_pkg::*;
#(
   parameter int A = 3
) (
   input  logic     clk,
   input  logic     rst,
   minx16_if.slave  bus
);
   state_e         r_state;
   logic           r_busy;
   logic [3:0]     r_op;
   logic [15:0]    r_a;
   logic [15:0]    r_b;
   logic [15:0]    r_acc;
   logic [3:0]     r_cnt;
   logic [A-1:0]   r_dst;
   logic [2:0]     r_wmode;
   logic [A-1:0]   r_rd;
   logic [15:0]    r_dd;
   logic [2:0]     r_wd;
   logic [3:0]     r_flags;

   logic           w_accept;
   logic [15:0]    w_x, w_y, w_sum;
   logic           w_sub, w_as_c, w_as_v;
   logic [15:0]    w_res;
   logic           w_c, w_v, w_single;
   logic [15:0]    w_sh_next;
   logic           w_sh_c;

   assign w_accept     = bus.in_valid & ~r_busy;
   assign bus.in_ready = ~r_busy;
   assign bus.busy     = r_busy;
   assign bus.rd       = r_rd;
   assign bus.dd       = r_dd;
   assign bus.wd       = r_wd;
   assign bus.flags    = r_flags;

   // The adder serves the issuing op in IDLE and the accumulate step in MUL.
   always_comb begin
      if (r_state == ST_MUL) begin
         w_x   = r_acc;
         w_y   = r_b[0] ? r_a : '0;
         w_sub = 1'b0;
      end else begin
         w_x   = bus.a;
         w_y   = bus.b;
         w_sub = (bus.op == OP_SUB) || (bus.op == OP_CMP);
      end
   end

   minx16_addsub u_addsub (
      .i_x   (w_x),
      .i_y   (w_y),
      .i_sub (w_sub),
      .o_sum (w_sum),
      .o_c   (w_as_c),
      .o_v   (w_as_v)
   );

   always_comb begin
      w_res    = bus.a;
      w_c      = 1'b0;
      w_v      = 1'b0;
      w_single = 1'b0;
      case (bus.op)
         OP_ADD, OP_SUB, OP_CMP: begin
            w_res = w_sum; w_c = w_as_c; w_v = w_as_v; w_single = 1'b1;
         end
         OP_AND: begin w_res = bus.a & bus.b; w_single = 1'b1; end
         OP_OR:  begin w_res = bus.a | bus.b; w_single = 1'b1; end
         OP_XOR: begin w_res = bus.a ^ bus.b; w_single = 1'b1; end
         OP_MOV: begin w_res = bus.b;         w_single = 1'b1; end
         OP_SHL, OP_SHR, OP_SAR: w_single = (bus.b[3:0] == 4'd0);
         default: ;
      endcase
   end

   always_comb begin
      case (r_op)
         OP_SHL:  begin w_sh_next = {r_a[14:0], 1'b0};      w_sh_c = r_a[15]; end
         OP_SHR:  begin w_sh_next = {1'b0, r_a[15:1]};      w_sh_c = r_a[0];  end
         default: begin w_sh_next = {r_a[15], r_a[15:1]};   w_sh_c = r_a[0];  end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_busy  <= 1'b0;
         r_op    <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_dst   <= '0;
         r_wmode <= WD_NONE;
         r_rd    <= '0;
         r_dd    <= '0;
         r_wd    <= WD_NONE;
         r_flags <= '0;
      end else begin
         r_wd <= WD_NONE;
         case (r_state)
            ST_IDLE: if (w_accept) begin
               r_op    <= bus.op;
               r_dst   <= bus.dst;
               r_wmode <= bus.wmode;
               if (w_single) begin
                  r_flags <= mk_flags(w_res, w_c, w_v);
                  if (bus.op != OP_CMP) begin
                     r_rd <= bus.dst;
                     r_dd <= w_res;
                     r_wd <= bus.wmode;
                  end
               end else if (bus.op == OP_MUL) begin
                  r_state <= ST_MUL;
                  r_busy  <= 1'b1;
                  r_a     <= bus.a;
                  r_b     <= bus.b;
                  r_acc   <= '0;
                  r_cnt   <= '0;
               end else if (bus.op == OP_SHL || bus.op == OP_SHR || bus.op == OP_SAR) begin
                  r_state <= ST_SHIFT;
                  r_busy  <= 1'b1;
                  r_a     <= bus.a;
                  r_cnt   <= bus.b[3:0];
               end
            end
            ST_MUL: begin
               r_acc <= w_sum;
               r_a   <= {r_a[14:0], 1'b0};
               r_b   <= {1'b0, r_b[15:1]};
               r_cnt <= r_cnt + 4'd1;
               if (r_cnt == 4'd15) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  r_rd    <= r_dst;
                  r_dd    <= w_sum;
                  r_wd    <= r_wmode;
                  r_flags <= mk_flags(w_sum, 1'b0, 1'b0);
               end
            end
            ST_SHIFT: begin
               r_a   <= w_sh_next;
               r_cnt <= r_cnt - 4'd1;
               if (r_cnt == 4'd1) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  r_rd    <= r_dst;
                  r_dd    <= w_sh_next;
                  r_wd    <= r_wmode;
                  r_flags <= mk_flags(w_sh_next, w_sh_c, 1'b0);
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_minx16_exec.sv
// Directed test of minx16_exec with hand-computed expected values.
module tb_minx16_exec;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;
   int   n_pulse;

   minx16_if #(.A(3)) bus ();

   minx16_exec #(.A(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] dst, input logic [2:0] wm);
      bus.in_valid = 1'b1;
      bus.op       = op;
      bus.a        = a;
      bus.b        = b;
      bus.dst      = dst;
      bus.wmode    = wm;
   endtask

   task automatic pulse(input string tag, input logic [2:0] rd, input logic [15:0] dd,
                        input logic [2:0] wd, input logic [3:0] fl);
      check({tag, ".rd"},    16'(bus.rd),    16'(rd));
      check({tag, ".dd"},    bus.dd,         dd);
      check({tag, ".wd"},    16'(bus.wd),    16'(wd));
      check({tag, ".flags"}, 16'(bus.flags), 16'(fl));
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst      = 1'b0;
      bus.in_valid = 1'b0;
      bus.op = '0; bus.a = '0; bus.b = '0; bus.dst = '0; bus.wmode = '0;
      repeat (3) tick();
      check("rst.wd",    16'(bus.wd),    16'h0);
      check("rst.dd",    bus.dd,         16'h0);
      check("rst.rd",    16'(bus.rd),    16'h0);
      check("rst.flags", 16'(bus.flags), 16'h0);
      check("rst.busy",  16'(bus.busy),  16'h0);
      rst = 1'b1;
      tick();
      check("rst.ready", 16'(bus.in_ready), 16'h1);

      // ADD overflow into sign bit
      issue(4'd0, 16'h7FFF, 16'h0001, 3'd2, 3'b011);
      tick();
      pulse("add", 3'd2, 16'h8000, 3'b011, 4'b0101);
      bus.in_valid = 1'b0;
      tick();
      check("add.wd_off", 16'(bus.wd), 16'h0);

      // SUB then CMP back to back
      issue(4'd1, 16'h0005, 16'h0005, 3'd1, 3'b011);
      tick();
      pulse("sub", 3'd1, 16'h0000, 3'b011, 4'b1000);
      issue(4'd10, 16'h0003, 16'h0004, 3'd4, 3'b011);
      tick();
      check("cmp.wd",    16'(bus.wd),    16'h0);
      check("cmp.flags", 16'(bus.flags), 16'b0110);

      // logic ops and ADD carry-out wrapping to zero, issued back to back
      issue(4'd0, 16'hFFFF, 16'h0001, 3'd7, 3'b001);
      tick();
      pulse("addc", 3'd7, 16'h0000, 3'b001, 4'b1010);
      issue(4'd2, 16'hF0F0, 16'h0FF0, 3'd3, 3'b100);
      tick();
      pulse("and", 3'd3, 16'h00F0, 3'b100, 4'b0000);
      issue(4'd3, 16'h1200, 16'h0034, 3'd3, 3'b010);
      tick();
      pulse("or", 3'd3, 16'h1234, 3'b010, 4'b0000);
      issue(4'd4, 16'hFFFF, 16'hFFFF, 3'd6, 3'b111);
      tick();
      pulse("xor", 3'd6, 16'h0000, 3'b111, 4'b1000);
      issue(4'd5, 16'h1111, 16'h8001, 3'd5, 3'b011);
      tick();
      pulse("mov", 3'd5, 16'h8001, 3'b011, 4'b0100);

      // MUL with a held op offered during the stall
      issue(4'd9, 16'h0123, 16'h0010, 3'd5, 3'b001);
      tick();
      issue(4'd0, 16'h0001, 16'h0002, 3'd3, 3'b011);
      for (int i = 0; i < 16; i++) begin
         check("mul.ready", 16'(bus.in_ready), 16'h0);
         check("mul.busy",  16'(bus.busy),     16'h1);
         check("mul.wd",    16'(bus.wd),       16'h0);
         tick();
      end
      pulse("mul", 3'd5, 16'h1230, 3'b001, 4'b0000);
      check("mul.ready_pulse", 16'(bus.in_ready), 16'h1);
      tick();
      pulse("held_add", 3'd3, 16'h0003, 3'b011, 4'b0000);
      bus.in_valid = 1'b0;
      tick();
      check("held_add.wd_off", 16'(bus.wd), 16'h0);

      // MUL discards upper product bits: 0xFFFF*0xFFFF = 0xFFFE0001
      issue(4'd9, 16'hFFFF, 16'hFFFF, 3'd1, 3'b011);
      tick();
      bus.in_valid = 1'b0;
      repeat (16) tick();
      pulse("mulwrap", 3'd1, 16'h0001, 3'b011, 4'b0000);

      // SAR by 4
      issue(4'd8, 16'h8001, 16'h0004, 3'd6, 3'b011);
      tick();
      bus.in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("sar.ready", 16'(bus.in_ready), 16'h0);
         tick();
      end
      pulse("sar", 3'd6, 16'hF800, 3'b011, 4'b0100);

      // SHR by 2 with upper b bits set, last bit out is 1
      issue(4'd7, 16'h0003, 16'hFFF2, 3'd2, 3'b001);
      tick();
      bus.in_valid = 1'b0;
      repeat (2) tick();
      pulse("shr", 3'd2, 16'h0000, 3'b001, 4'b1010);

      // SHL by zero is single-cycle
      issue(4'd6, 16'h8000, 16'h0000, 3'd4, 3'b011);
      tick();
      pulse("shl0", 3'd4, 16'h8000, 3'b011, 4'b0100);
      check("shl0.ready", 16'(bus.in_ready), 16'h1);

      // reserved op: no write, flags held
      issue(4'd12, 16'h0000, 16'h0000, 3'd1, 3'b011);
      tick();
      bus.in_valid = 1'b0;
      check("rsv.wd",    16'(bus.wd),    16'h0);
      check("rsv.flags", 16'(bus.flags), 16'b0100);
      check("rsv.ready", 16'(bus.in_ready), 16'h1);

      // reset during MUL aborts it
      issue(4'd9, 16'h0003, 16'h0005, 3'd2, 3'b011);
      tick();
      bus.in_valid = 1'b0;
      repeat (8) tick();
      rst = 1'b0;
      #1;
      check("abort.wd",    16'(bus.wd),    16'h0);
      check("abort.flags", 16'(bus.flags), 16'h0);
      check("abort.busy",  16'(bus.busy),  16'h0);
      repeat (2) tick();
      rst = 1'b1;
      tick();
      check("abort.ready", 16'(bus.in_ready), 16'h1);
      n_pulse = 0;
      for (int i = 0; i < 20; i++) begin
         if (bus.wd != 3'b000) n_pulse++;
         tick();
      end
      check("abort.no_pulse", 16'(n_pulse), 16'h0);
      issue(4'd0, 16'h0002, 16'h0003, 3'd1, 3'b011);
      tick();
      bus.in_valid = 1'b0;
      pulse("post_add", 3'd1, 16'h0005, 3'b011, 4'b0000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/minx16_exec.md
Name: minx16_exec

Overview:
Execute stage of the Minx16 datapath. It sits directly downstream of the 16-bit register file. It consumes the two read operands and the decoded op from the decoder. It produces the register-file write port (rd/dd/wd) plus condition flags. Single-cycle ALU ops issue back-to-back; MUL and variable shifts are iterative and stall issue via in_ready.

Parameters:
A, 3, register address width (2**A registers); matches register-file address width

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  reset, asynchronous, active-low
in_valid  in  1  decoder presents an op this cycle
in_ready  out  1  block accepts op on this edge when in_valid=1
op  in  4  operation code (see Behaviour)
dst  in  A  destination register index
wmode  in  3  register-file write-mode code applied to the result
a  in  16  operand A (register-file port a)
b  in  16  operand B (register-file port b / immediate)
rd  out  A  write address to register file
dd  out  16  write data to register file
wd  out  3  write-mode code; 000 = no write
flags  out  4  {Z,N,C,V}, registered
busy  out  1  iterative op in progress

Behaviour:
- Reset (rst=0, async): state IDLE, rd=0, dd=0, wd=000, flags=0, busy=0, in_ready=1 (after deassert). Reset mid-MUL/shift aborts the op with no write.
- Accept = in_valid & in_ready on rising edge; a, b, op, dst, wmode are captured then and not re-sampled. Forwarding/hazards are the decoder's responsibility.
- Ops: 0 ADD, 1 SUB (a-b), 2 AND, 3 OR, 4 XOR, 5 MOV (dd=b), 6 SHL, 7 SHR, 8 SAR, 9 MUL (low 16 bits), 10 CMP (SUB, flags only), 11-15 reserved.
- Single-cycle ops (0-5, 10; shifts with b[3:0]=0): result registered at the accept edge. rd=dst, dd=result and wd=wmode are valid for exactly the following cycle, then wd returns to 000. in_ready stays 1, so back-to-back accepts produce consecutive write pulses.
- CMP and reserved ops: wd=000. Reserved ops leave flags unchanged.
- States: IDLE, MUL, SHIFT.
  - MUL: entered on accept; 16 iterations, one shift-add per cycle over b[0..15], counter 4 bits. Accept at edge E; iterations on edges E+1..E+16. The write pulse occurs in the cycle after E+16. in_ready=0 and busy=1 for cycles E+1..E+16. The machine returns to IDLE at E+16, so in_ready=1 during the write-pulse cycle, and a new op may be accepted there.
  - SHIFT: amount n=b[3:0] (b[15:4] ignored), 1 bit per cycle. It takes n cycles, with the same pulse/ready rules as MUL (n replaces 16). SHL/SHR fill 0; SAR replicates bit 15.
- Flags update on the same edge the result registers:
  - Z = (result==0); N = result[15].
  - ADD: C = carry out, V = signed overflow.
  - SUB/CMP: C = borrow (a<b unsigned), V = signed overflow.
  - Logic/MOV/MUL: C=0, V=0.
  - Shifts: C = last bit shifted out (0 if n=0), V=0.
- All arithmetic is modulo 2^16. MUL upper product bits are discarded.
- wmode is passed through verbatim; the block never interprets byte lanes.

Decomposition:
- Package minx16_pkg: op codes, wd mode constants (WD_NONE=000, WD_LO=001, WD_HI=010, WD_FULL=011, swap variants 100-111), flag bit indices, state encoding.
- One combinational sub-module, minx16_addsub: 16-bit add/sub returning sum, C and V. It is shared by ADD, SUB, CMP and the MUL accumulate step.

Test Plan:
- ADD a=0x7FFF b=0x0001 dst=2 wmode=011 -> next cycle rd=2 dd=0x8000 wd=011, flags Z=0 N=1 C=0 V=1; following cycle wd=000.
- SUB 5-5, then CMP 3-4 on consecutive edges -> pulse1: dd=0x0000, Z=1 C=0; pulse2: wd=000, flags N=1 C=1 Z=0 V=0.
- MUL a=0x0123 b=0x0010 -> in_ready=0 for 16 cycles, then dd=0x1230 wd=wmode for one cycle; op offered during busy is held, then accepted in the pulse cycle.
- SAR a=0x8001 b=0x0004 -> 4 busy cycles, dd=0xF800, C=0, N=1; SHL a=0x8000 b=0 -> single-cycle, dd=0x8000, C=0.
- Assert rst low at MUL iteration 8 -> wd stays 000, no write pulse, flags=0, in_ready=1 after release; next ADD completes normally.
